// File: rtl/gcd_arbiter.sv
// Round-robin front end that serialises requester jobs onto one GCD engine.
// One job in flight: IDLE grant -> ISSUE start pulse -> WAIT result -> RESP hand-back.
module gcd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] op_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] op_b_i,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [WIDTH-1:0]         resp_data_o,
  output logic                     resp_err_o,
  output logic                     eng_req_o,
  output logic [WIDTH-1:0]         eng_op_a_o,
  output logic [WIDTH-1:0]         eng_op_b_o,
  input  logic                     eng_busy_i,
  input  logic                     eng_valid_i,
  input  logic [WIDTH-1:0]         eng_result_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e               state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        ptr_d;
  logic [IW-1:0]        gnt_q;
  logic [IW-1:0]        pick;
  logic                 found;
  logic                 grant;
  int                   idx;
  logic [CW-1:0]        cnt_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [WIDTH-1:0]     resp_data_q;
  logic                 resp_err_q;
  logic                 eng_req_q;
  logic [WIDTH-1:0]     eng_a_q;
  logic [WIDTH-1:0]     eng_b_q;

  // First valid requester at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign ptr_d = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

  assign grant = (state_q == S_IDLE) && !eng_busy_i
               && found && !rst_i;

  assign req_ready_o  = grant ? (NUM_REQ'(1) << pick) : '0;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign eng_req_o    = eng_req_q;
  assign eng_op_a_o   = eng_a_q;
  assign eng_op_b_o   = eng_b_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      eng_req_q    <= 1'b0;
      eng_a_q      <= '0;
      eng_b_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (grant) begin
            gnt_q     <= pick;
            ptr_q     <= ptr_d;
            eng_a_q   <= op_a_i[int'(pick)*WIDTH +: WIDTH];
            eng_b_q   <= op_b_i[int'(pick)*WIDTH +: WIDTH];
            eng_req_q <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          eng_req_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          // A result on the final counted cycle still beats the timeout
          if (eng_valid_i) begin
            resp_data_q  <= eng_result_i;
            resp_err_q   <= 1'b0;
            resp_valid_q <= NUM_REQ'(1) << gnt_q;
            state_q      <= S_RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= NUM_REQ'(1) << gnt_q;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Randomised bench for gcd_arbiter with a queue-free round-robin model
// and a behavioural GCD engine driven from the stimulus tasks.
module tb_gcd_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] op_a_i;
  logic [N*W-1:0] op_b_i;
  logic [N-1:0]   resp_valid_o;
  logic           resp_ready_i;
  logic [W-1:0]   resp_data_o;
  logic           resp_err_o;
  logic           eng_req_o;
  logic [W-1:0]   eng_op_a_o;
  logic [W-1:0]   eng_op_b_o;
  logic           eng_busy_i;
  logic           eng_valid_i;
  logic [W-1:0]   eng_result_i;

  gcd_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o),
    .eng_req_o    (eng_req_o),
    .eng_op_a_o   (eng_op_a_o),
    .eng_op_b_o   (eng_op_b_o),
    .eng_busy_i   (eng_busy_i),
    .eng_valid_i  (eng_valid_i),
    .eng_result_i (eng_result_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Requester-side model state
  logic         pend [N];
  logic [W-1:0] pa   [N];
  logic [W-1:0] pb   [N];
  int           ptr;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid_i[k]       = pend[k];
      op_a_i[k*W +: W]     = pa[k];
      op_b_i[k*W +: W]     = pb[k];
    end
  endtask

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  function automatic logic [21:0] all_out();
    return {req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
            eng_req_o, eng_op_a_o, eng_op_b_o};
  endfunction

  // vcyc: WAIT cycle (1..32) carrying the engine result; 0 = never
  task automatic serve(input int vcyc, input int rdly, output int waited);
    int           exp_k;
    logic [W-1:0] a, b, r, d0;
    logic [N-1:0] oh;
    exp_k = -1;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (ptr + i) % N;
      if (exp_k < 0 && pend[j]) exp_k = j;
    end
    waited = 0;
    #1;
    while (req_ready_o == '0 && waited < 40) begin
      cyc();
      #1;
      waited++;
    end
    if (req_ready_o == '0 || exp_k < 0) begin
      check("grant_wait", 64'(waited), 64'(0));
      return;
    end
    oh = N'(1) << exp_k;
    check("grant", 64'(req_ready_o), 64'(oh));
    a = pa[exp_k];
    b = pb[exp_k];
    pend[exp_k] = 1'b0;
    ptr = (exp_k + 1) % N;
    cyc();
    drive();
    #1;
    check("eng_req", 64'(eng_req_o), 64'(1));
    check("eng_a", 64'(eng_op_a_o), 64'(a));
    check("eng_b", 64'(eng_op_b_o), 64'(b));
    check("rdy_busy", 64'(req_ready_o), 64'(0));
    r = gcd(a, b);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      eng_result_i = r;
      eng_valid_i  = (k == vcyc);
      #1;
      if (k == 1) check("eng_req_pulse", 64'(eng_req_o), 64'(0));
      check("no_resp", 64'(resp_valid_o), 64'(0));
      if (k == vcyc) break;
    end
    cyc();
    eng_valid_i = 1'b0;
    #1;
    d0 = (vcyc == 0) ? '0 : r;
    check("resp_v", 64'(resp_valid_o), 64'(oh));
    check("resp_d", 64'(resp_data_o), 64'(d0));
    check("resp_e", 64'(resp_err_o), 64'(vcyc == 0));
    for (int k = 0; k < rdly; k++) begin
      cyc();
      #1;
      check("hold_v", 64'(resp_valid_o), 64'(oh));
      check("hold_d", 64'(resp_data_o), 64'(d0));
      check("hold_rdy", 64'(req_ready_o), 64'(0));
    end
    resp_ready_i = 1'b1;
    cyc();
    resp_ready_i = 1'b0;
  endtask

  initial begin
    int w;
    int v;
    rst_i = 1'b1;
    req_valid_i = '0;
    op_a_i = '0;
    op_b_i = '0;
    resp_ready_i = 1'b0;
    eng_busy_i = 1'b0;
    eng_valid_i = 1'b0;
    eng_result_i = '0;
    ptr = 0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b0;
      pa[k] = '0;
      pb[k] = '0;
    end
    cyc();
    cyc();
    rst_i = 1'b0;
    #1;
    check("reset_out", 64'(all_out()), 64'(0));
    cyc();

    // Single job on port 0, engine answers on the 6th WAIT cycle
    pend[0] = 1'b1; pa[0] = 4'd12; pb[0] = 4'd8;
    drive();
    serve(6, 0, w);

    // Fresh pointer, all four ports request together
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    ptr = 0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b1;
      pa[k] = W'($urandom);
      pb[k] = W'($urandom);
    end
    drive();
    for (int k = 0; k < N; k++) serve(2 + k, 0, w);

    // Port 2 served, then 1 and 3 contend: 3 first
    pend[2] = 1'b1; pa[2] = 4'd9; pb[2] = 4'd6;
    drive();
    serve(3, 0, w);
    pend[1] = 1'b1; pa[1] = 4'd10; pb[1] = 4'd4;
    pend[3] = 1'b1; pa[3] = 4'd15; pb[3] = 4'd5;
    drive();
    serve(1, 0, w);
    serve(1, 0, w);

    // Long response hold with port 0 waiting behind it
    pend[2] = 1'b1; pa[2] = 4'd14; pb[2] = 4'd7;
    pend[0] = 1'b1; pa[0] = 4'd0;  pb[0] = 4'd5;
    drive();
    serve(4, 6, w);
    serve(2, 0, w);
    check("regrant_lat", 64'(w), 64'(0));

    // Engine busy blocks the grant
    pend[1] = 1'b1; pa[1] = 4'd0; pb[1] = 4'd0;
    eng_busy_i = 1'b1;
    drive();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("busy_rdy", 64'(req_ready_o), 64'(0));
      cyc();
    end
    eng_busy_i = 1'b0;
    serve(1, 0, w);

    // Timeout, then a result on the last counted cycle
    pend[3] = 1'b1; pa[3] = 4'd6; pb[3] = 4'd9;
    drive();
    serve(0, 1, w);
    pend[0] = 1'b1; pa[0] = 4'd8; pb[0] = 4'd12;
    drive();
    serve(32, 0, w);

    // Reset during WAIT, late engine pulse must be ignored
    pend[1] = 1'b1; pa[1] = 4'd9; pb[1] = 4'd6;
    drive();
    #1;
    check("rst_grant", 64'(req_ready_o), 64'(4'b0010));
    pend[1] = 1'b0;
    cyc();
    drive();
    cyc();
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    eng_valid_i = 1'b1;
    eng_result_i = 4'd3;
    #1;
    check("rst_out", 64'(all_out()), 64'(0));
    cyc();
    eng_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rst_quiet", 64'(all_out()), 64'(0));
      cyc();
    end
    ptr = 0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b1;
      pa[k] = W'($urandom);
      pb[k] = W'($urandom);
    end
    drive();
    for (int k = 0; k < N; k++) serve(1, 0, w);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      int any;
      any = 0;
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && ($urandom % 2) == 1) begin
          pend[k] = 1'b1;
          pa[k] = W'($urandom);
          pb[k] = W'($urandom);
        end
        if (pend[k]) any = 1;
      end
      if (any == 0) begin
        int k;
        k = int'($urandom % N);
        pend[k] = 1'b1;
        pa[k] = W'($urandom);
        pb[k] = 4'd0;
      end
      drive();
      case ($urandom % 8)
        0: v = 0;
        1: v = 32;
        default: v = int'($urandom_range(1, 12));
      endcase
      serve(v, int'($urandom % 4), w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 Parameter WIDTH, default 4, operand and result width.
REQ-003 Parameter TIMEOUT, default 32, maximum cycles spent waiting for an engine result.
REQ-004 clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 req_valid_i  input  NUM_REQ  per-requester job request.
REQ-007 req_ready_o  output  NUM_REQ  one-hot job accept; a job transfers when valid and ready are both high.
REQ-008 op_a_i, op_b_i  input  NUM_REQ*WIDTH  packed operands; requester k occupies slice [k*WIDTH +: WIDTH].
REQ-009 resp_valid_o  output  NUM_REQ  one-hot result-available flag.
REQ-010 resp_ready_i  input  1  response consumed; sampled only while resp_valid_o is non-zero.
REQ-011 resp_data_o  output  WIDTH  GCD result.
REQ-012 resp_err_o  output  1  timeout flag qualifying resp_data_o.
REQ-013 eng_req_o  output  1  single-cycle start pulse to the GCD engine.
REQ-014 eng_op_a_o, eng_op_b_o  output  WIDTH  registered operands to the engine.
REQ-015 eng_busy_i, eng_valid_i  input  1  engine busy level and single-cycle done pulse.
REQ-016 eng_result_i  input  WIDTH  engine result, valid when eng_valid_i is high.

Function
REQ-017 The block SHALL implement the FSM IDLE, ISSUE, WAIT, RESP and serve exactly one job at a time.
REQ-018 IDLE: when any req_valid_i bit is set and eng_busy_i=0, the block SHALL grant one requester, assert its req_ready_o bit combinationally in that cycle, capture its operands, and go to ISSUE.
REQ-019 The grant SHALL be round-robin: search starts at pointer p, and on grant p becomes (granted index + 1) mod NUM_REQ.
REQ-020 In IDLE with eng_busy_i=1, req_ready_o SHALL stay 0.
REQ-021 ISSUE: eng_req_o SHALL be 1 for exactly one cycle with the captured operands, then the FSM goes to WAIT and clears the timeout counter.
REQ-022 eng_op_a_o and eng_op_b_o SHALL hold the captured operands from ISSUE until the next grant.
REQ-023 WAIT: on eng_valid_i=1, the block SHALL register eng_result_i into resp_data_o, set resp_err_o=0, and go to RESP.
REQ-024 WAIT: the counter SHALL increment each cycle, and at TIMEOUT cycles without eng_valid_i the block SHALL set resp_data_o=0, set resp_err_o=1, and go to RESP.
REQ-025 If eng_valid_i arrives in the same cycle the timeout is reached, the valid result SHALL win.
REQ-026 RESP: resp_valid_o SHALL be one-hot on the granted index, and resp_data_o and resp_err_o SHALL be stable until resp_ready_i=1; that cycle the FSM returns to IDLE.
REQ-027 No grant SHALL occur in ISSUE, WAIT or RESP; at most one req_ready_o bit SHALL be high in any cycle.
REQ-028 eng_valid_i outside WAIT SHALL be ignored.
REQ-029 Latency: a grant in cycle t gives eng_req_o in t+1; an engine valid in cycle v gives resp_valid_o from v+1.
REQ-030 Operands SHALL pass unmodified, including zero values.

Reset
REQ-031 When rst_i=1 at a clock edge, the block SHALL set FSM=IDLE, p=0, and the counter to 0, and all outputs SHALL be 0 from the next cycle, regardless of state.
REQ-032 Reset mid-job SHALL discard the job, and no response SHALL be issued for it; a late eng_valid_i SHALL be ignored per REQ-028.

Verification
REQ-033 Port 0 job a=12, b=8, engine model returns 4 after 5 cycles -> req_ready_o=0001; eng_req_o one cycle later with 12/8; resp_valid_o=0001, resp_data_o=4, resp_err_o=0.
REQ-034 After reset, all four ports request simultaneously and hold -> grants in order 0,1,2,3, each response on the matching one-hot bit.
REQ-035 After port 2 is served, ports 1 and 3 are pending -> port 3 is granted before port 1.
REQ-036 resp_ready_i held low 6 cycles in RESP with port 0 requesting -> resp_valid_o and resp_data_o constant and req_ready_o=0 throughout; grant one cycle after resp_ready_i rises.
REQ-037 Engine model never pulses valid -> after 32 WAIT cycles resp_valid_o is set with resp_err_o=1 and resp_data_o=0; a valid in cycle 32 instead yields resp_err_o=0.
REQ-038 rst_i pulsed during WAIT, then eng_valid_i pulsed -> all outputs 0 and no response issued; the next request is granted starting from port 0.
